// File: rtl/mu_pkg.sv
// rtl/mu_pkg.sv - shared widths, Caddr/opcode encodings, control-store words and dispatch lookups
package mu_pkg;

    localparam int UPC_W = 4;
    localparam int OP_W  = 6;
    localparam int MIR_W = 15;

    typedef enum logic [1:0] {
        CADDR_FETCH = 2'd0,
        CADDR_DISP1 = 2'd1,
        CADDR_DISP2 = 2'd2,
        CADDR_SEQ   = 2'd3
    } caddr_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;

    localparam logic [UPC_W-1:0] UPC_FETCH     = 4'd0;
    localparam logic [UPC_W-1:0] UPC_MEM_ADDR  = 4'd2;
    localparam logic [UPC_W-1:0] UPC_MEM_READ  = 4'd3;
    localparam logic [UPC_W-1:0] UPC_R_EXEC    = 4'd6;
    localparam logic [UPC_W-1:0] UPC_BEQ       = 4'd8;
    localparam logic [UPC_W-1:0] UPC_JUMP      = 4'd9;
    localparam logic [UPC_W-1:0] UPC_ADDI_EXEC = 4'd10;
    localparam logic [UPC_W-1:0] UPC_TRAP      = 4'd15;

    // Field order: PCWr PCWrCond IorD MemRd | TransIn | ALUOp | ALUSrcB | ALUSrcA RegWr | Caddr
    localparam logic [MIR_W-1:0] W_FETCH     = 15'h4913;
    localparam logic [MIR_W-1:0] W_DECODE    = 15'h0231;
    localparam logic [MIR_W-1:0] W_MEM_ADDR  = 15'h022A;
    localparam logic [MIR_W-1:0] W_MEM_READ  = 15'h1B03;
    localparam logic [MIR_W-1:0] W_LOAD_WB   = 15'h0404;
    localparam logic [MIR_W-1:0] W_R_EXEC    = 15'h028B;
    localparam logic [MIR_W-1:0] W_R_WB      = 15'h0504;
    localparam logic [MIR_W-1:0] W_BEQ       = 15'h2648;
    localparam logic [MIR_W-1:0] W_JUMP      = 15'h4700;
    localparam logic [MIR_W-1:0] W_ADDI_EXEC = 15'h022B;
    localparam logic [MIR_W-1:0] W_ADDI_WB   = 15'h0504;
    localparam logic [MIR_W-1:0] W_ZERO      = 15'h0000;

    typedef struct packed {
        logic             valid;
        logic [UPC_W-1:0] target;
    } disp_t;

    function automatic disp_t disp1_lookup(input logic [OP_W-1:0] op);
        disp_t d;
        d.valid = 1'b1;
        case (op)
            OP_RTYPE: d.target = UPC_R_EXEC;
            OP_LW:    d.target = UPC_MEM_ADDR;
            OP_BEQ:   d.target = UPC_BEQ;
            OP_J:     d.target = UPC_JUMP;
            OP_ADDI:  d.target = UPC_ADDI_EXEC;
            default: begin
                d.valid  = 1'b0;
                d.target = UPC_FETCH;
            end
        endcase
        return d;
    endfunction

    function automatic disp_t disp2_lookup(input logic [OP_W-1:0] op);
        disp_t d;
        d.valid  = (op == OP_LW);
        d.target = (op == OP_LW) ? UPC_MEM_READ : UPC_FETCH;
        return d;
    endfunction

endpackage

// File: rtl/mu_ctrl_store.sv
// rtl/mu_ctrl_store.sv - combinational control-store ROM read and DISP1/DISP2 opcode lookup
module mu_ctrl_store
    import mu_pkg::*;
(
    input  logic [UPC_W-1:0] addr,
    input  logic [OP_W-1:0]  opcode,
    output logic [MIR_W-1:0] word,
    output logic             disp1_valid,
    output logic [UPC_W-1:0] disp1_target,
    output logic             disp2_valid,
    output logic [UPC_W-1:0] disp2_target
);

    disp_t d1;
    disp_t d2;

    always_comb begin
        word = W_ZERO;
        case (addr)
            4'd0:  word = W_FETCH;
            4'd1:  word = W_DECODE;
            4'd2:  word = W_MEM_ADDR;
            4'd3:  word = W_MEM_READ;
            4'd4:  word = W_LOAD_WB;
            4'd6:  word = W_R_EXEC;
            4'd7:  word = W_R_WB;
            4'd8:  word = W_BEQ;
            4'd9:  word = W_JUMP;
            4'd10: word = W_ADDI_EXEC;
            4'd11: word = W_ADDI_WB;
            default: word = W_ZERO;
        endcase
    end

    always_comb begin
        d1 = disp1_lookup(opcode);
        d2 = disp2_lookup(opcode);
    end

    assign disp1_valid  = d1.valid;
    assign disp1_target = d1.target;
    assign disp2_valid  = d2.valid;
    assign disp2_target = d2.target;

endmodule

// File: rtl/mu_sequencer.sv
// rtl/mu_sequencer.sv - micro-PC sequencer with MemRd stall; MUSEQ_ILLEGAL_TRAP_EN parks illegal opcodes at word 15
module mu_sequencer
    import mu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [OP_W-1:0]  opcode,
    input  logic             mem_ready,
    output logic [MIR_W-1:0] micro_ir,
    output logic [UPC_W-1:0] upc,
    output logic             instr_done,
    output logic             illegal_op
);

    logic [MIR_W-1:0] rom_word;
    logic [UPC_W-1:0] next_upc;
    logic             disp1_valid;
    logic [UPC_W-1:0] disp1_target;
    logic             disp2_valid;
    logic [UPC_W-1:0] disp2_target;
    logic             stall;
    logic             retire_fetch;
    caddr_t           caddr;

    assign caddr = caddr_t'(micro_ir[1:0]);
    assign stall = micro_ir[11] && !mem_ready;

    // The ROM is addressed by the next address so micro_ir and upc load together.
    mu_ctrl_store u_ctrl_store (
        .addr         (next_upc),
        .opcode       (opcode),
        .word         (rom_word),
        .disp1_valid  (disp1_valid),
        .disp1_target (disp1_target),
        .disp2_valid  (disp2_valid),
        .disp2_target (disp2_target)
    );

`ifdef MUSEQ_ILLEGAL_TRAP_EN
    localparam logic [UPC_W-1:0] ILLEGAL_NEXT = UPC_TRAP;
    logic illegal_hit;
    logic illegal_q;
    logic parked;

    assign parked      = (upc == UPC_TRAP);
    assign illegal_hit = ((caddr == CADDR_DISP1) && !disp1_valid) ||
                         ((caddr == CADDR_DISP2) && !disp2_valid);
    assign illegal_op  = illegal_q;
`else
    localparam logic [UPC_W-1:0] ILLEGAL_NEXT = UPC_FETCH;
    localparam logic parked = 1'b0;
    assign illegal_op = 1'b0;
`endif

    always_comb begin
        next_upc = UPC_FETCH;
        case (caddr)
            CADDR_FETCH: next_upc = UPC_FETCH;
            CADDR_DISP1: next_upc = disp1_valid ? disp1_target : ILLEGAL_NEXT;
            CADDR_DISP2: next_upc = disp2_valid ? disp2_target : ILLEGAL_NEXT;
            CADDR_SEQ:   next_upc = upc + 4'd1;
            default:     next_upc = UPC_FETCH;
        endcase
        if (parked) begin
            next_upc = UPC_TRAP;
        end
    end

    assign retire_fetch = (caddr == CADDR_FETCH) && !parked;

    always_ff @(posedge clk) begin
        if (rst) begin
            upc        <= UPC_FETCH;
            micro_ir   <= W_FETCH;
            instr_done <= 1'b0;
        end else if (stall) begin
            instr_done <= 1'b0;
        end else begin
            upc        <= next_upc;
            micro_ir   <= rom_word;
            instr_done <= retire_fetch;
        end
    end

`ifdef MUSEQ_ILLEGAL_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else if (!stall && illegal_hit) begin
            illegal_q <= 1'b1;
        end
    end
`endif

endmodule
